// File: rtl/mac_pkg.sv
// Shared MAC transmit definitions: scheduler FSM encoding and XGMII lane count.
package mac_pkg;

    localparam int XGMII_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_IFG   = 2'd3
    } tx_sched_state_t;

endpackage

// File: rtl/xgmii_pause_timer.sv
// 802.3x PAUSE timer: quanta counter plus a per-quantum word sub-counter.
// Data is considered paused while the quanta count is non-zero.
module xgmii_pause_timer #(
    parameter int QUANTA_WORDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pause_load_i,
    input  logic [15:0] pause_quanta_i,
    output logic        data_paused_o
);

    localparam int SUB_W = (QUANTA_WORDS > 1) ? $clog2(QUANTA_WORDS) : 1;
    localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(QUANTA_WORDS - 1);

    logic [15:0]      quanta_q, quanta_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    // Next count: a fresh PAUSE frame always overrides the running countdown.
    always_comb begin
        quanta_d = quanta_q;
        sub_d    = sub_q;
        if (pause_load_i) begin
            quanta_d = pause_quanta_i;
            sub_d    = SUB_RELOAD;
        end else if (quanta_q != 16'd0) begin
            if (sub_q == '0) begin
                quanta_d = quanta_q - 16'd1;
                sub_d    = SUB_RELOAD;
            end else begin
                sub_d = sub_q - 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quanta_q <= 16'd0;
            sub_q    <= '0;
        end else begin
            quanta_q <= quanta_d;
            sub_q    <= sub_d;
        end
    end

    assign data_paused_o = (quanta_q != 16'd0);

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// XGMII TX scheduler: arbitrates control (priority) and data frames onto the
// TX engine, enforces the inter-frame gap in words and honours XGMII
// back-pressure and received PAUSE quanta.
// Optional build macro XGMII_TX_SCHED_DIC_EN enables deficit idle count.
//
// state | meaning
// IDLE  | waiting for a request; held while XGMII back-pressure is active
// GRANT | single cycle with the chosen grant asserted
// BUSY  | frame in flight, waiting for the word carrying /T/
// IFG   | counting idle words down to zero (frozen by back-pressure)
module xgmii_tx_scheduler
    import mac_pkg::*;
#(
    parameter int IFG_BYTES    = 12,
    parameter int QUANTA_WORDS = 16
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_ctrl_req,
    output logic        o_ctrl_gnt,
    input  logic        i_data_req,
    output logic        o_data_gnt,
    input  logic        i_tx_done,
    input  logic [1:0]  i_tx_term_lane,
    input  logic        i_xgmii_pause,
    input  logic        i_rx_pause_valid,
    input  logic [15:0] i_rx_pause_quanta,
    output logic        o_tx_busy,
    output logic        o_data_paused
);

    tx_sched_state_t state_q, state_d;
    logic [5:0]      gap_cnt_q, gap_cnt_d;
    logic            ctrl_gnt_q, ctrl_gnt_d;
    logic            data_gnt_q, data_gnt_d;
    logic            tx_busy_q;
    logic            data_paused;

    logic [1:0]      idle_tail;
    logic [6:0]      gap_e;
    logic [4:0]      gap_f;
    logic [1:0]      gap_r;
    logic [5:0]      gap_n;

    // Bytes still owed after the idle lanes that follow /T/ in its own word.
    assign idle_tail = 2'(XGMII_LANES - 1) - i_tx_term_lane;
    assign gap_e     = 7'(IFG_BYTES) - {5'd0, idle_tail};
    assign gap_f     = gap_e[6:2];
    assign gap_r     = gap_e[1:0];

`ifdef XGMII_TX_SCHED_DIC_EN
    logic [1:0] dic_q, dic_d, dic_next;
    logic [2:0] dic_sum;

    assign dic_sum = {1'b0, dic_q} + {1'b0, gap_r};

    // Round down while the accumulated deficit fits in three bytes, else
    // round up and pay the deficit back.
    always_comb begin
        gap_n    = {1'b0, gap_f};
        dic_next = dic_q;
        if (gap_r != 2'd0) begin
            dic_next = dic_sum[1:0];
            if (dic_sum > 3'd3) begin
                gap_n = {1'b0, gap_f} + 6'd1;
            end
        end
    end

    // Deficit register, only advanced when a frame actually terminates.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dic_q <= 2'd0;
        end else begin
            dic_q <= dic_d;
        end
    end
`else
    assign gap_n = {1'b0, gap_f} + {5'd0, (gap_r != 2'd0)};
`endif

    xgmii_pause_timer #(
        .QUANTA_WORDS (QUANTA_WORDS)
    ) u_pause_timer (
        .clk_i          (clk),
        .rst_ni         (i_reset_n),
        .pause_load_i   (i_rx_pause_valid),
        .pause_quanta_i (i_rx_pause_quanta),
        .data_paused_o  (data_paused)
    );

    // Next-state and registered-grant decode.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        ctrl_gnt_d = 1'b0;
        data_gnt_d = 1'b0;
`ifdef XGMII_TX_SCHED_DIC_EN
        dic_d      = dic_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!i_xgmii_pause) begin
                    if (i_ctrl_req) begin
                        state_d    = ST_GRANT;
                        ctrl_gnt_d = 1'b1;
                    end else if (i_data_req && !data_paused) begin
                        state_d    = ST_GRANT;
                        data_gnt_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (i_tx_done) begin
`ifdef XGMII_TX_SCHED_DIC_EN
                    dic_d = dic_next;
`endif
                    if (gap_n == 6'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_n;
                        state_d   = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                if (!i_xgmii_pause) begin
                    gap_cnt_d = gap_cnt_q - 6'd1;
                    if (gap_cnt_q == 6'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, gap counter and output registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= 6'd0;
            ctrl_gnt_q <= 1'b0;
            data_gnt_q <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            ctrl_gnt_q <= ctrl_gnt_d;
            data_gnt_q <= data_gnt_d;
            tx_busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign o_ctrl_gnt    = ctrl_gnt_q;
    assign o_data_gnt    = data_gnt_q;
    assign o_tx_busy     = tx_busy_q;
    assign o_data_paused = data_paused;

endmodule
